// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 word mux.
// Grants one requester at a time, bounds tenure with a hold counter while
// others wait, and registers the selected word with a valid flag.
module mux4_rr_arbiter #(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned MAX_HOLD    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             request,
  input  logic [WORD_LENGTH-1:0] Data_0,
  input  logic [WORD_LENGTH-1:0] Data_1,
  input  logic [WORD_LENGTH-1:0] Data_2,
  input  logic [WORD_LENGTH-1:0] Data_3,
  output logic [3:0]             grant,
  output logic [1:0]             selector,
  output logic                   busy,
  output logic [WORD_LENGTH-1:0] data_out,
  output logic                   data_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                 r_state;
  logic [3:0]             r_grant;
  logic [1:0]             r_sel;
  logic [1:0]             r_ptr;
  logic [7:0]             r_hold;
  logic [WORD_LENGTH-1:0] r_data;
  logic                   r_valid;

  state_t                 w_state_nxt;
  logic [3:0]             w_grant_nxt;
  logic [1:0]             w_sel_nxt;
  logic [1:0]             w_ptr_nxt;
  logic [7:0]             w_hold_nxt;
  logic [1:0]             w_win;
  logic [1:0]             w_idx;
  logic                   w_found;
  logic                   w_others;
  logic                   w_hold_max;
  logic [WORD_LENGTH-1:0] w_mux;

  // Winner search: first set request starting at the priority pointer.
  always_comb begin
    w_win   = r_ptr;
    w_idx   = r_ptr;
    w_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && request[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_others   = |(request & ~r_grant);
  assign w_hold_max = (r_hold == 8'(MAX_HOLD));

  // Next-state logic; release is checked before preemption.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    case (r_state)
      IDLE: begin
        if (|request) begin
          w_state_nxt = GRANT;
          w_grant_nxt = 4'b0001 << w_win;
          w_sel_nxt   = w_win;
          w_hold_nxt  = 8'd1;
        end
      end
      GRANT: begin
        if (!request[r_sel] || (w_hold_max && w_others)) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = r_sel + 2'd1;
        end else if (!w_hold_max) begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Shared 4:1 word mux driven by the registered selector.
  always_comb begin
    w_mux = Data_0;
    case (r_sel)
      2'd0:    w_mux = Data_0;
      2'd1:    w_mux = Data_1;
      2'd2:    w_mux = Data_2;
      2'd3:    w_mux = Data_3;
      default: w_mux = Data_0;
    endcase
  end

  // Output stage: capture the owner's word while a grant is active.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (|r_grant) begin
      r_data  <= w_mux;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign grant      = r_grant;
  assign selector   = r_sel;
  assign busy       = (r_state == GRANT);
  assign data_out   = r_data;
  assign data_valid = r_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with hand-computed expectations.
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  request;
  logic [31:0] Data_0, Data_1, Data_2, Data_3;
  logic [3:0]  grant;
  logic [1:0]  selector;
  logic        busy;
  logic [31:0] data_out;
  logic        data_valid;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [31:0] exp_word [4];

  mux4_rr_arbiter #(.WORD_LENGTH(32), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .request   (request),
    .Data_0    (Data_0),
    .Data_1    (Data_1),
    .Data_2    (Data_2),
    .Data_3    (Data_3),
    .grant     (grant),
    .selector  (selector),
    .busy      (busy),
    .data_out  (data_out),
    .data_valid(data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    request  = 4'b0000;
    Data_0   = 32'h1111_0000;
    Data_1   = 32'h1111_0001;
    Data_2   = 32'hCAFE_0002;
    Data_3   = 32'h1111_0003;
    tick();
    tick();
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_sel", {30'd0, selector}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    reset = 1'b1;
    tick();

    // Single requester 2: grant after one edge, data one edge later.
    request = 4'b0100;
    tick();
    check("t1_grant", {28'd0, grant}, 32'h4);
    check("t1_sel", {30'd0, selector}, 32'd2);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_valid0", {31'd0, data_valid}, 32'd0);
    tick();
    check("t1_data", data_out, 32'hCAFE_0002);
    check("t1_valid1", {31'd0, data_valid}, 32'd1);
    tick();
    request = 4'b0000;
    tick();
    check("t1_rel_grant", {28'd0, grant}, 32'd0);
    check("t1_rel_busy", {31'd0, busy}, 32'd0);
    check("t1_rel_valid", {31'd0, data_valid}, 32'd1);
    tick();
    check("t1_idle_valid", {31'd0, data_valid}, 32'd0);

    // ptr is now 3: requester 3 beats 0 and 1.
    request = 4'b1011;
    tick();
    check("ptr3_grant", {28'd0, grant}, 32'h8);
    check("ptr3_sel", {30'd0, selector}, 32'd3);
    // Owner 3 releases, ptr wraps to 0, then requester 1 beats 3.
    request = 4'b0010;
    tick();
    check("wrap_bubble", {28'd0, grant}, 32'd0);
    request = 4'b1010;
    tick();
    check("wrap_grant", {28'd0, grant}, 32'h2);
    check("wrap_sel", {30'd0, selector}, 32'd1);
    request = 4'b0000;
    tick();

    // All four requesting from ptr=0: 8 cycles each, one bubble between.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_word[0] = 32'hD000_0000;
    exp_word[1] = 32'hD000_0001;
    exp_word[2] = 32'hD000_0002;
    exp_word[3] = 32'hD000_0003;
    Data_0 = exp_word[0];
    Data_1 = exp_word[1];
    Data_2 = exp_word[2];
    Data_3 = exp_word[3];
    request = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int o;
      o = n % 4;
      for (int k = 0; k < 8; k++) begin
        tick();
        check($sformatf("rr_grant_o%0d_k%0d", n, k), {28'd0, grant}, 32'd1 << o);
        check($sformatf("rr_sel_o%0d_k%0d", n, k), {30'd0, selector}, 32'(o));
        check($sformatf("rr_valid_o%0d_k%0d", n, k), {31'd0, data_valid}, (k == 0) ? 32'd0 : 32'd1);
        if (k != 0)
          check($sformatf("rr_data_o%0d_k%0d", n, k), data_out, exp_word[o]);
      end
      tick();
      check($sformatf("rr_bubble_grant_%0d", n), {28'd0, grant}, 32'd0);
      check($sformatf("rr_bubble_busy_%0d", n), {31'd0, busy}, 32'd0);
      check($sformatf("rr_bubble_valid_%0d", n), {31'd0, data_valid}, 32'd1);
      check($sformatf("rr_bubble_data_%0d", n), data_out, exp_word[o]);
    end

    // Lone requester 0 for 20 cycles: hold saturates, never preempted.
    request = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("solo_grant_%0d", c), {28'd0, grant}, 32'h1);
      check($sformatf("solo_valid_%0d", c), {31'd0, data_valid}, (c == 0) ? 32'd0 : 32'd1);
    end

    // Owner drops at hold==MAX_HOLD with 1 waiting: plain release, ptr=1.
    request = 4'b0010;
    tick();
    check("relpri_grant", {28'd0, grant}, 32'd0);
    check("relpri_busy", {31'd0, busy}, 32'd0);
    request = 4'b0011;
    tick();
    check("relpri_next", {28'd0, grant}, 32'h2);
    request = 4'b0000;
    tick();
    tick();

    // Asynchronous reset mid-grant (owner 2, hold=5).
    reset = 1'b0;
    tick();
    reset = 1'b1;
    request = 4'b0100;
    tick();
    tick();
    tick();
    tick();
    tick();
    check("amid_grant_pre", {28'd0, grant}, 32'h4);
    check("amid_data_pre", data_out, 32'hD000_0002);
    #2;
    reset = 1'b0;
    #1;
    check("arst_grant", {28'd0, grant}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_valid", {31'd0, data_valid}, 32'd0);
    check("arst_data", data_out, 32'd0);
    tick();
    reset = 1'b1;
    request = 4'b0110;
    tick();
    check("arst_after_grant", {28'd0, grant}, 32'h2);
    check("arst_after_sel", {30'd0, selector}, 32'd1);
    request = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
